multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit in the execute stage, beside the combinational ALU.
- Takes the same operands the ALU takes. Its registered result is selected into the execute result path in place of the ALU output when data_resultRDY is high.
- Multicycle: the pipeline stalls on ctrl_MULT/ctrl_DIV until data_resultRDY.

---
 rtl/multdiv_unit.sv | 125 ++++++++++++
 tb/tb_multdiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit.
// Optional macro MULTDIV_DIV0_FAST_EN: divide-by-zero completes one edge after start.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH:0]     mplier;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH:0]     dmag;
   logic               neg;
   logic               dzero;

   // Magnitudes are one bit wider so -2^(WIDTH-1) does not wrap.
   function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] x;
      x = {v[WIDTH-1], v};
      return v[WIDTH-1] ? -x : x;
   endfunction

   logic [WIDTH:0]     mag_a;
   logic [WIDTH:0]     mag_b;
   logic               start;
   logic               last;
   logic               fast_dz;
   logic [WIDTH+1:0]   rem_sh;
   logic [WIDTH+1:0]   diff;
   logic               take;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   qs;

   assign mag_a  = mag(data_operandA);
   assign mag_b  = mag(data_operandB);
   assign start  = ctrl_MULT | ctrl_DIV;
   assign last   = (count == CNT_W'(WIDTH));
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dmag};
   assign take   = ~diff[WIDTH+1];
   assign prod   = neg ? -acc : acc;
   assign qs     = neg ? -quo : quo;

`ifdef MULTDIV_DIV0_FAST_EN
   assign fast_dz = dzero;
`else
   assign fast_dz = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         count          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (start) begin
            state  <= ctrl_MULT ? MULT_RUN : DIV_RUN;
            count  <= '0;
            neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dzero  <= (data_operandB == '0);
            acc    <= '0;
            mcand  <= {{(WIDTH-1){1'b0}}, mag_a};
            mplier <= mag_b;
            rem    <= '0;
            quo    <= mag_a[WIDTH-1:0];
            dmag   <= mag_b;
         end else begin
            unique case (state)
               MULT_RUN: begin
                  if (last) begin
                     state          <= DONE;
                     data_resultRDY <= 1'b1;
                     data_result    <= prod[WIDTH-1:0];
                     data_exception <= prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
                  end else begin
                     if (mplier[0]) acc <= acc + mcand;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                     count  <= count + 1'b1;
                  end
               end
               DIV_RUN: begin
                  if (last || fast_dz) begin
                     state          <= DONE;
                     data_resultRDY <= 1'b1;
                     if (dzero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                     end else begin
                        // Only -2^(WIDTH-1) / -1 yields a positive quotient with MSB set.
                        data_result    <= qs;
                        data_exception <= ~neg & quo[WIDTH-1];
                     end
                  end else begin
                     rem   <= take ? diff[WIDTH:0] : rem_sh[WIDTH:0];
                     quo   <= {quo[WIDTH-2:0], take};
                     count <= count + 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int tests = 0;
   int fails = 0;

`ifdef MULTDIV_DIV0_FAST_EN
   localparam int DZ_LAT = 1;
`else
   localparam int DZ_LAT = 33;
`endif

   always #5 clock = ~clock;

   multdiv_unit dut (
      .clock(clock),
      .reset(reset),
      .data_operandA(data_operandA),
      .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT),
      .ctrl_DIV(ctrl_DIV),
      .data_result(data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY)
   );

   task automatic start_op(input logic m, input logic d,
                           input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
   endtask

   // Edges after the start edge until RDY is seen; -1 on timeout.
   task automatic wait_rdy(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      tests++;
      if (data_result !== 32'h0) begin
         fails++;
         $display("FAIL reset_result got %h want 0", data_result);
      end
      tests++;
      if (data_exception !== 1'b0) begin
         fails++;
         $display("FAIL reset_exc got %b want 0", data_exception);
      end
      tests++;
      if (data_resultRDY !== 1'b0) begin
         fails++;
         $display("FAIL reset_rdy got %b want 0", data_resultRDY);
      end
      reset = 1'b0;
   endtask

   task automatic test_ops(input logic is_mult);
      logic [31:0] va[6];
      logic [31:0] vb[6];
      logic [31:0] vr[6];
      logic        ve[6];
      int n;
      logic [31:0] held;
      if (is_mult) begin
         va = '{32'd6, 32'h00010000, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
         vb = '{32'd7, 32'h00010000, 32'd5, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
         vr = '{32'd42, 32'h0, 32'hFFFFFFF1, 32'h80000000, 32'h80000000, 32'd1};
         ve = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
         va = '{32'hFFFFFFF9, 32'h80000000, 32'd0, 32'd100, 32'hFFFFFF9C, 32'd7};
         vb = '{32'd2, 32'hFFFFFFFF, 32'd5, 32'd7, 32'd7, 32'hFFFFFFFE};
         vr = '{32'hFFFFFFFD, 32'h80000000, 32'd0, 32'd14, 32'hFFFFFFF2, 32'hFFFFFFFD};
         ve = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      for (int i = 0; i < 6; i++) begin
         start_op(is_mult, ~is_mult, va[i], vb[i]);
         wait_rdy(n);
         tests++;
         if (n !== 33) begin
            fails++;
            $display("FAIL %s%0d_latency got %0d want 33", is_mult ? "mul" : "div", i, n);
         end
         tests++;
         if (data_result !== vr[i]) begin
            fails++;
            $display("FAIL %s%0d_result got %h want %h", is_mult ? "mul" : "div", i, data_result, vr[i]);
         end
         tests++;
         if (data_exception !== ve[i]) begin
            fails++;
            $display("FAIL %s%0d_exc got %b want %b", is_mult ? "mul" : "div", i, data_exception, ve[i]);
         end
         held = data_result;
         @(posedge clock);
         #1;
         tests++;
         if (data_resultRDY !== 1'b0 || data_result !== vr[i]) begin
            fails++;
            $display("FAIL %s%0d_hold rdy %b result %h want rdy 0 result %h",
                     is_mult ? "mul" : "div", i, data_resultRDY, data_result, held);
         end
      end
   endtask

   task automatic test_div0();
      logic [31:0] dv[2];
      int n;
      dv = '{32'd100, 32'hFFFFFF00};
      for (int i = 0; i < 2; i++) begin
         start_op(1'b1, 1'b0, 32'd3, 32'd5);
         wait_rdy(n);
         start_op(1'b0, 1'b1, dv[i], 32'd0);
         wait_rdy(n);
         tests++;
         if (n !== DZ_LAT) begin
            fails++;
            $display("FAIL div0_%0d_latency got %0d want %0d", i, n, DZ_LAT);
         end
         tests++;
         if (data_result !== 32'h0 || data_exception !== 1'b1) begin
            fails++;
            $display("FAIL div0_%0d_value got %h/%b want 0/1", i, data_result, data_exception);
         end
         @(posedge clock);
         #1;
         tests++;
         if (data_resultRDY !== 1'b0) begin
            fails++;
            $display("FAIL div0_%0d_rdy_width got %b want 0", i, data_resultRDY);
         end
      end
   endtask

   task automatic test_both();
      int n;
      start_op(1'b1, 1'b1, 32'd6, 32'd7);
      wait_rdy(n);
      tests++;
      if (n !== 33 || data_result !== 32'd42) begin
         fails++;
         $display("FAIL both_ctrl got lat %0d result %h want 33/0000002a", n, data_result);
      end
   endtask

   task automatic test_abort();
      int n;
      int early;
      int extra;
      early = 0;
      start_op(1'b1, 1'b0, 32'd6, 32'd7);
      repeat (9) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) early++;
      end
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      wait_rdy(n);
      tests++;
      if (early !== 0 || n !== 33) begin
         fails++;
         $display("FAIL abort_latency early %0d lat %0d want 0/33", early, n);
      end
      tests++;
      if (data_result !== 32'd14 || data_exception !== 1'b0) begin
         fails++;
         $display("FAIL abort_result got %h/%b want 0000000e/0", data_result, data_exception);
      end
      extra = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) extra++;
      end
      tests++;
      if (extra !== 0) begin
         fails++;
         $display("FAIL abort_extra_rdy got %0d want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clock);
      ctrl_MULT = 1'b1;
      data_operandA = 32'd6;
      data_operandB = 32'd7;
      @(negedge clock);
      data_operandA = 32'd2;
      data_operandB = 32'd3;
      @(negedge clock);
      data_operandA = 32'd9;
      data_operandB = 32'd9;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      wait_rdy(n);
      tests++;
      if (n !== 33 || data_result !== 32'd81) begin
         fails++;
         $display("FAIL back_to_back got lat %0d result %h want 33/00000051", n, data_result);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      int n;
      start_op(1'b1, 1'b0, 32'd6, 32'd7);
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      tests++;
      if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_outputs got %h/%b/%b want 0/0/0",
                  data_result, data_exception, data_resultRDY);
      end
      pulses = 0;
      repeat (50) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) pulses++;
      end
      tests++;
      if (pulses !== 0 || data_result !== 32'h0) begin
         fails++;
         $display("FAIL reset_mid_no_rdy got pulses %0d result %h want 0/0", pulses, data_result);
      end
      start_op(1'b1, 1'b0, 32'hFFFFFFFA, 32'd7);
      wait_rdy(n);
      tests++;
      if (n !== 33 || data_result !== 32'hFFFFFFD6) begin
         fails++;
         $display("FAIL reset_mid_recover got lat %0d result %h want 33/ffffffd6", n, data_result);
      end
   endtask

   initial begin
      test_reset();
      test_ops(1'b1);
      test_ops(1'b0);
      test_div0();
      test_both();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
